// File: rtl/fir_sched.sv
// FIR sequencing and coefficient-configuration controller: paces the filter with a
// programmable sample-enable strobe and double-buffers the tap coefficients.
module fir_sched #(
   parameter int NB_COEF = 8,
   parameter int N_TAPS  = 4,
   parameter int NB_ADDR = 2,
   parameter int NB_DIV  = 4
) (
   input  logic                        clock,
   input  logic                        i_reset,
   input  logic                        i_run,
   input  logic [NB_DIV-1:0]           i_div,
   input  logic                        i_coef_valid,
   input  logic [NB_ADDR-1:0]          i_coef_addr,
   input  logic [NB_COEF-1:0]          i_coef_data,
   output logic                        o_coef_ready,
   input  logic                        i_commit,
   output logic                        o_enable,
   output logic [N_TAPS*NB_COEF-1:0]   o_coefs,
   output logic                        o_swap,
   output logic                        o_pending
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   logic                state;
   logic [NB_DIV-1:0]   cnt;
   logic [NB_DIV-1:0]   div_l;
   logic                pend;
   logic                swap;
   logic [NB_COEF-1:0]  shadow      [N_TAPS];
   logic [NB_COEF-1:0]  shadow_next [N_TAPS];
   logic [NB_COEF-1:0]  active      [N_TAPS];
   logic                enable;
   logic                wr_accept;

   assign enable       = (state == ST_RUN) && (cnt == div_l);
   assign wr_accept    = i_coef_valid && !pend;
   assign o_enable     = enable;
   assign o_coef_ready = !pend;
   assign o_pending    = pend;
   assign o_swap       = swap;

   // Shadow bank including this cycle's write, so a same-edge commit copies the merged value.
   always_comb begin
      for (int k = 0; k < N_TAPS; k++) begin
         shadow_next[k] = shadow[k];
      end
      if (wr_accept && (int'(i_coef_addr) < N_TAPS)) begin
         shadow_next[i_coef_addr] = i_coef_data;
      end
   end

   always_comb begin
      o_coefs = '0;
      for (int k = 0; k < N_TAPS; k++) begin
         o_coefs[k*NB_COEF +: NB_COEF] = active[k];
      end
   end

   // A swap in RUN waits for a strobe edge so one sample never mixes coefficient sets.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         div_l  <= '0;
         pend   <= 1'b0;
         swap   <= 1'b0;
         shadow <= '{default: '0};
         active <= '{default: '0};
      end else begin
         swap   <= 1'b0;
         shadow <= shadow_next;
         case (state)
            ST_IDLE: begin
               if (i_commit) begin
                  active <= shadow_next;
                  swap   <= 1'b1;
               end
               if (i_run) begin
                  state <= ST_RUN;
                  cnt   <= '0;
                  div_l <= i_div;
               end
            end
            default: begin
               if (i_run) begin
                  if (pend && enable) begin
                     active <= shadow_next;
                     pend   <= 1'b0;
                     swap   <= 1'b1;
                  end else if (i_commit) begin
                     pend <= 1'b1;
                  end
                  if (cnt == div_l) begin
                     cnt   <= '0;
                     div_l <= i_div;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  // Leaving RUN flushes any outstanding commit so IDLE never holds a stale request.
                  if (pend || i_commit) begin
                     active <= shadow_next;
                     swap   <= 1'b1;
                  end
                  pend  <= 1'b0;
                  state <= ST_IDLE;
                  cnt   <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_sched.sv
// Self-checking bench for fir_sched: directed scenarios followed by random traffic,
// all compared cycle by cycle against a behavioural model of the controller.
module tb_fir_sched;

   logic        clock;
   logic        i_reset;
   logic        i_run;
   logic [3:0]  i_div;
   logic        i_coef_valid;
   logic [1:0]  i_coef_addr;
   logic [7:0]  i_coef_data;
   logic        o_coef_ready;
   logic        i_commit;
   logic        o_enable;
   logic [31:0] o_coefs;
   logic        o_swap;
   logic        o_pending;

   int total = 0;
   int bad   = 0;

   // Behavioural model: running flag, position within the sample period, latched period.
   bit        m_running;
   int        m_pos;
   int        m_period;
   bit        m_pend;
   bit        m_swap;
   logic [7:0] m_shadow [4];
   logic [7:0] m_active [4];

   fir_sched #(.NB_COEF(8), .N_TAPS(4), .NB_ADDR(2), .NB_DIV(4)) dut (
      .clock        (clock),
      .i_reset      (i_reset),
      .i_run        (i_run),
      .i_div        (i_div),
      .i_coef_valid (i_coef_valid),
      .i_coef_addr  (i_coef_addr),
      .i_coef_data  (i_coef_data),
      .o_coef_ready (o_coef_ready),
      .i_commit     (i_commit),
      .o_enable     (o_enable),
      .o_coefs      (o_coefs),
      .o_swap       (o_swap),
      .o_pending    (o_pending)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic resetModel();
      m_running = 1'b0;
      m_pos     = 0;
      m_period  = 1;
      m_pend    = 1'b0;
      m_swap    = 1'b0;
      for (int k = 0; k < 4; k++) begin
         m_shadow[k] = 8'h00;
         m_active[k] = 8'h00;
      end
   endtask

   function automatic bit modelStrobe();
      return m_running && (m_pos == m_period - 1);
   endfunction

   task automatic checkAll();
      checkOutput("enable",     {31'd0, o_enable},     {31'd0, modelStrobe()});
      checkOutput("coefs",      o_coefs,               {m_active[3], m_active[2], m_active[1], m_active[0]});
      checkOutput("swap",       {31'd0, o_swap},       {31'd0, m_swap});
      checkOutput("pending",    {31'd0, o_pending},    {31'd0, m_pend});
      checkOutput("coef_ready", {31'd0, o_coef_ready}, {31'd0, !m_pend});
   endtask

   // Advance the model over one rising edge using the inputs currently applied.
   task automatic modelEdge();
      bit         strobe;
      bit         do_swap;
      logic [7:0] merged [4];
      strobe  = modelStrobe();
      do_swap = 1'b0;
      for (int k = 0; k < 4; k++) merged[k] = m_shadow[k];
      if (i_coef_valid && !m_pend) merged[i_coef_addr] = i_coef_data;
      if (!m_running) begin
         if (i_commit) do_swap = 1'b1;
         if (i_run) begin
            m_running = 1'b1;
            m_pos     = 0;
            m_period  = int'(i_div) + 1;
         end
      end else if (i_run) begin
         if (m_pend && strobe) begin
            do_swap = 1'b1;
            m_pend  = 1'b0;
         end else if (i_commit) begin
            m_pend = 1'b1;
         end
         if (strobe) begin
            m_pos    = 0;
            m_period = int'(i_div) + 1;
         end else begin
            m_pos++;
         end
      end else begin
         if (m_pend || i_commit) do_swap = 1'b1;
         m_pend    = 1'b0;
         m_running = 1'b0;
         m_pos     = 0;
      end
      for (int k = 0; k < 4; k++) begin
         m_shadow[k] = merged[k];
         if (do_swap) m_active[k] = merged[k];
      end
      m_swap = do_swap;
   endtask

   task automatic applyStimulus(input logic run, input logic [3:0] div, input logic valid,
                                input logic [1:0] addr, input logic [7:0] data, input logic commit);
      i_run        = run;
      i_div        = div;
      i_coef_valid = valid;
      i_coef_addr  = addr;
      i_coef_data  = data;
      i_commit     = commit;
      @(posedge clock);
      modelEdge();
      #1;
      checkAll();
   endtask

   // Assert reset between edges, scramble inputs while held, release between edges.
   task automatic doReset(input int hold_cycles);
      i_reset = 1'b0;
      resetModel();
      #1;
      checkAll();
      for (int c = 0; c < hold_cycles; c++) begin
         i_run        = 1'($urandom);
         i_div        = 4'($urandom);
         i_coef_valid = 1'($urandom);
         i_coef_addr  = 2'($urandom);
         i_coef_data  = 8'($urandom);
         i_commit     = 1'($urandom);
         @(posedge clock);
         #1;
         checkAll();
      end
      i_reset = 1'b1;
   endtask

   initial begin
      bit         run_r;
      logic [3:0] div_r;
      i_reset      = 1'b0;
      i_run        = 1'b0;
      i_div        = 4'd0;
      i_coef_valid = 1'b0;
      i_coef_addr  = 2'd0;
      i_coef_data  = 8'd0;
      i_commit     = 1'b0;
      resetModel();
      #2;
      checkAll();
      @(posedge clock);
      #1;
      doReset(3);

      // Rate with period 4, then continuous strobe with period 1.
      for (int c = 0; c < 20; c++) applyStimulus(1, 4'd3, 0, 0, 0, 0);
      applyStimulus(0, 4'd3, 0, 0, 0, 0);
      applyStimulus(1, 4'd0, 0, 0, 0, 0);
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1, 4'd0, 0, 0, 0, 0);
         checkOutput("div0_continuous", {31'd0, o_enable}, 32'd1);
      end
      applyStimulus(0, 4'd0, 0, 0, 0, 0);
      applyStimulus(0, 4'd0, 0, 0, 0, 0);

      // IDLE load with the last write merged into the same-edge commit.
      applyStimulus(0, 4'd0, 1, 2'd0, 8'h40, 0);
      applyStimulus(0, 4'd0, 1, 2'd1, 8'hC0, 0);
      applyStimulus(0, 4'd0, 1, 2'd2, 8'h20, 0);
      applyStimulus(0, 4'd0, 1, 2'd3, 8'h7F, 1);
      checkOutput("idle_load_coefs", o_coefs, 32'h7F20C040);
      checkOutput("idle_load_swap", {31'd0, o_swap}, 32'd1);
      applyStimulus(0, 4'd0, 0, 0, 0, 0);

      // Run-time swap: period 8, commit when cnt is 2, write attempted while pending.
      applyStimulus(0, 4'd7, 1, 2'd0, 8'h11, 0);
      applyStimulus(1, 4'd7, 0, 0, 0, 0);
      applyStimulus(1, 4'd7, 0, 0, 0, 0);
      applyStimulus(1, 4'd7, 0, 0, 0, 0);
      applyStimulus(1, 4'd7, 0, 0, 0, 1);
      checkOutput("run_pending", {31'd0, o_pending}, 32'd1);
      applyStimulus(1, 4'd7, 1, 2'd1, 8'hAA, 0);
      for (int c = 0; c < 8; c++) applyStimulus(1, 4'd7, 0, 0, 0, 0);
      checkOutput("run_swap_tap1", {24'd0, o_coefs[15:8]}, 32'h000000C0);

      // Stop with a commit pending.
      applyStimulus(1, 4'd7, 0, 0, 0, 1);
      applyStimulus(1, 4'd7, 0, 0, 0, 0);
      applyStimulus(0, 4'd7, 0, 0, 0, 0);
      checkOutput("stop_swap", {31'd0, o_swap}, 32'd1);
      applyStimulus(0, 4'd7, 0, 0, 0, 0);

      // Async reset mid-RUN with a commit pending.
      applyStimulus(0, 4'd5, 1, 2'd2, 8'h5A, 0);
      applyStimulus(1, 4'd5, 0, 0, 0, 0);
      applyStimulus(1, 4'd5, 0, 0, 0, 1);
      doReset(2);
      for (int c = 0; c < 4; c++) applyStimulus(0, 4'd0, 0, 0, 0, 0);

      // Random traffic with occasional resets.
      run_r = 1'b0;
      div_r = 4'd2;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 24) == 0) run_r = !run_r;
         if ($urandom_range(0, 9) == 0) div_r = 4'($urandom_range(0, 6));
         applyStimulus(run_r, div_r, 1'($urandom), 2'($urandom), 8'($urandom),
                       $urandom_range(0, 7) == 0);
         if ((c % 400) == 399) doReset(1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fir_sched.md
# fir_sched

FIR sequencing and coefficient-configuration controller. Generates the sample-enable strobe that paces the FIR filter at a programmable rate. Holds a writable shadow coefficient bank and an active bank that drives the filter taps. Swaps shadow into active only at a sample boundary, so a filter output is never computed with mixed coefficient sets. Sits between the control/register side and the FIR datapath in the filter top level.

## Interface
- NB_COEF, 8, coefficient width (signed, two's complement)
- N_TAPS, 4, number of filter taps
- NB_ADDR, 2, coefficient address width; N_TAPS <= 2^NB_ADDR
- NB_DIV, 4, rate-divider width

- clock  in  1  system clock; all state updates on the rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_run  in  1  level; 1 = strobe generation active
- i_div  in  NB_DIV  enable period minus one (period = i_div+1 cycles)
- i_coef_valid  in  1  coefficient write request
- i_coef_addr  in  NB_ADDR  tap index being written
- i_coef_data  in  NB_COEF  coefficient value
- o_coef_ready  out  1  shadow bank accepts writes
- i_commit  in  1  single-cycle request to copy shadow into active
- o_enable  out  1  sample-enable strobe to FIR
- o_coefs  out  N_TAPS*NB_COEF  active bank; tap k at bits [k*NB_COEF +: NB_COEF]
- o_swap  out  1  one-cycle pulse: new active bank visible this cycle
- o_pending  out  1  commit requested, swap not yet done

## Operation
- States: IDLE, RUN. Registers: cnt (NB_DIV), div_l (NB_DIV), pend, shadow[N_TAPS], active[N_TAPS].
- IDLE, i_run=1: go to RUN, cnt<=0, div_l<=i_div.
- RUN, i_run=1: if cnt==div_l then cnt<=0 and div_l<=i_div, else cnt<=cnt+1.
- RUN, i_run=0: go to IDLE next edge, cnt<=0.
- o_enable = (state==RUN) && (cnt==div_l).
  - This is a decode of registered state only.
  - i_div changes take effect only at period boundaries.
- Write acceptance: a write is accepted on an edge where i_coef_valid && o_coef_ready.
  - It updates shadow[i_coef_addr].
  - Writes to addresses >= N_TAPS are accepted and discarded.
- o_coef_ready = !pend.
- Commit while IDLE: active <= shadow on the same edge.
  - If a write is accepted on that edge, the copied value includes it (merged next-shadow value).
- Commit while RUN: pend<=1. Swap (active <= shadow, pend<=0) occurs on the first edge where o_enable==1.
  - That edge's FIR sample uses the old set. All later samples use the new set.
- RUN->IDLE transition with pend=1: swap occurs on the transition edge.
- Commit while pend=1: ignored (no second swap).
- o_swap registered: high for exactly the one cycle following the updating edge, coincident with the new o_coefs.

## Timing
- Reset (async assert, i_reset=0) values:
  - state=IDLE, cnt=0, div_l=0, pend=0.
  - shadow and active all zero.
  - o_enable=0, o_swap=0, o_pending=0, o_coef_ready=1, o_coefs=0.
- Reset mid-operation: all of the above immediately. Pending commit and shadow contents are lost.
- Start latency: i_run sampled high at edge E0.
  - o_enable first high in the cycle after edge E0+div_l.
  - It then repeats every div_l+1 cycles.
  - i_div=0 gives o_enable=1 every cycle in RUN.
- Stop latency: i_run sampled low at edge E.
  - o_enable=0 from edge E.
  - The strobe visible in the cycle before E still counts as a sample.
- Commit-to-swap latency:
  - In IDLE: 1 edge.
  - In RUN: until the next o_enable edge, worst case div_l+1 edges.
- Simultaneous i_commit and o_enable in RUN: the current strobe edge does not swap; the next strobe swaps.

## Test plan
- Reset: hold i_reset=0, toggle the other inputs.
  - Expect o_enable=0, o_coefs=0, o_coef_ready=1, o_swap=0, o_pending=0.
- Rate: i_div=3, i_run=1 for 20 cycles.
  - Expect o_enable pulses exactly every 4 cycles, first pulse 4 cycles after run start.
  - Repeat with i_div=0: expect continuous high.
- IDLE load: write taps 0..3 = 0x40, 0xC0, 0x20, 0x7F, then commit with the tap-3 write on the same cycle.
  - Expect o_coefs=0x7F20C040 and o_swap pulse 1 cycle later.
- Run-time swap: i_div=7 running, commit at cnt=2.
  - Expect o_pending=1 and o_coef_ready=0 until the o_enable edge.
  - Expect swap there, o_swap one cycle later, and a write attempted while pending not to take effect.
- Stop with pending: commit, then drop i_run before the strobe.
  - Expect swap on the RUN->IDLE edge and o_pending=0 afterwards.
- Async reset mid-RUN with pending.
  - Expect all outputs at reset values immediately, no swap pulse after release.
